io_input_fifo: RTL and testbench
================================

IO_INPUT_FIFO -- requirements
Module: io_input_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8: number of 32-bit entries; power of two, 2..256.
REQ-002 The block SHALL derive AW = log2(DEPTH); it is not a user parameter.
REQ-003 The block SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port wr_en  input  1  producer write request.
REQ-006 The block SHALL have port wr_data  input  32  word to enqueue.
REQ-007 The block SHALL have port rd_en  input  1  CPU consume strobe, one word per asserted cycle.
REQ-008 The block SHALL have port DIn  output  32  head word, wired directly to the CPU DIn input.
REQ-009 The block SHALL have port full  output  1  high when count == DEPTH.
REQ-010 The block SHALL have port empty  output  1  high when count == 0.
REQ-011 The block SHALL have port count  output  AW+1  number of stored words, 0..DEPTH.

Function
REQ-012 The block SHALL accept a write, storing wr_data at wr_ptr, when wr_en is high and full is low or rd_en is accepted in the same cycle.
REQ-013 The block SHALL accept a read, advancing rd_ptr, when rd_en is high and empty is low.
REQ-014 The block SHALL ignore a write while full with no accepted read; the stored data and count stay unchanged.
REQ-015 The block SHALL ignore a read while empty; pointers and count stay unchanged.
REQ-016 Simultaneous read and write while full SHALL both be accepted; count stays DEPTH.
REQ-017 Simultaneous read and write while empty SHALL accept the write only; count becomes 1; no bypass to DIn in the same cycle.
REQ-018 Simultaneous accepted read and write in any other state SHALL leave count unchanged.
REQ-019 wr_ptr and rd_ptr SHALL be AW bits wide and wrap from DEPTH-1 to 0.
REQ-020 DIn SHALL equal mem[rd_ptr] when empty is low and 32'h0000_0000 when empty is high, combinationally from registered state.
REQ-021 A written word SHALL appear on DIn the cycle after the write edge if the FIFO was empty; read-to-next-word latency SHALL be one edge.
REQ-022 full, empty and count SHALL be derived from the registered count with no extra cycle of latency.
REQ-023 Words SHALL be delivered in strict FIFO order with no loss or duplication.

Reset
REQ-024 When reset is high at a rising edge, the block SHALL clear wr_ptr, rd_ptr and count to 0, ignoring wr_en and rd_en that cycle.
REQ-025 After reset the outputs SHALL be empty=1, full=0, count=0, DIn=0; memory contents need not be cleared.
REQ-026 Reset asserted mid-stream SHALL discard all stored words in that cycle.

Configuration
REQ-027 When IO_INPUT_FIFO_ERRFLAG_EN is defined, the block SHALL add output ovf (1 bit) that is set on any ignored write (REQ-014).
REQ-028 When IO_INPUT_FIFO_ERRFLAG_EN is defined, the block SHALL add output udf (1 bit) that is set on any ignored read (REQ-015).
REQ-029 ovf and udf SHALL be sticky and cleared only by reset.
REQ-030 When IO_INPUT_FIFO_ERRFLAG_EN is undefined, ovf and udf SHALL not exist and the remaining behaviour SHALL be identical.

Verification
REQ-031 Reset, then write 32'h0000_0011, 32'h0000_0022, 32'h0000_0033 on consecutive cycles -> count=3; DIn=32'h11; three rd_en pulses yield DIn 22, 33, then 0 with empty=1.
REQ-032 DEPTH=8: write 9 words 1..9 -> full=1 after the 8th; word 9 is dropped; ovf=1 if enabled; reading 8 times returns 1..8.
REQ-033 Full FIFO with rd_en=wr_en=1 and wr_data=32'hDEAD_BEEF for one cycle -> count stays 8; DIn advances to word 2; DEADBEEF is delivered last.
REQ-034 Empty FIFO with rd_en=wr_en=1 and wr_data=32'hCAFE_0001 -> next cycle count=1, DIn=CAFE0001; udf stays 0.
REQ-035 Fill to 5 words, assert reset for one cycle with wr_en=1 -> count=0, empty=1, DIn=0, ovf=udf=0.
REQ-036 Stream 20 words with random rd_en/wr_en gaps at DEPTH=8 -> pointer wrap is exercised and output order matches a scoreboard.

Source files
------------

// File: rtl/io_input_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : io_input_fifo
//  Description : Synchronous 32-bit input FIFO feeding the CPU DIn port.
//                The head word is presented combinationally on DIn, and DIn
//                reads zero while the FIFO is empty. A write is accepted
//                while full when a read is accepted in the same cycle.
//                Optional build macro IO_INPUT_FIFO_ERRFLAG_EN adds sticky
//                ovf (dropped write) and udf (dropped read) flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module io_input_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [31:0]              wr_data,
    input  logic                     rd_en,
    output logic [31:0]              DIn,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
`ifdef IO_INPUT_FIFO_ERRFLAG_EN
    ,
    output logic                     ovf,
    output logic                     udf
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic w_full;
    logic w_empty;
    logic w_rd_acc;
    logic w_wr_acc;

    // Status flags come straight from the registered count
    always_comb begin
        w_full  = (r_count == c_depth);
        w_empty = (r_count == '0);
        // A read needs data; a write needs room or a same-cycle read freeing a slot.
        // On an empty FIFO the read is refused, so the write is not bypassed.
        w_rd_acc = rd_en && !w_empty;
        w_wr_acc = wr_en && (!w_full || w_rd_acc);
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents survive reset since the pointers define validity
    always_ff @(posedge clk) begin
        if (!reset && w_wr_acc) r_mem[r_wr_ptr] <= wr_data;
    end

`ifdef IO_INPUT_FIFO_ERRFLAG_EN
    logic r_ovf;
    logic r_udf;

    // Sticky error flags; a read/write pair on an empty FIFO is a legal
    // operation (the write lands), so it does not count as an underflow
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (wr_en && !w_wr_acc)            r_ovf <= 1'b1;
            if (rd_en && w_empty && !wr_en)    r_udf <= 1'b1;
        end
    end

    assign ovf = r_ovf;
    assign udf = r_udf;
`endif

    assign DIn   = w_empty ? 32'h0000_0000 : r_mem[r_rd_ptr];
    assign full  = w_full;
    assign empty = w_empty;
    assign count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_io_input_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_io_input_fifo
//  Description : Self-checking bench for io_input_fifo against a queue model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_io_input_fifo;

    localparam int DEPTH = 8;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wr_en = 1'b0;
    logic [31:0]   wr_data = '0;
    logic          rd_en = 1'b0;
    logic [31:0]   DIn;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
`ifdef IO_INPUT_FIFO_ERRFLAG_EN
    logic          ovf;
    logic          udf;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: the FIFO contents as a queue plus sticky flags
    logic [31:0] q[$];
    logic        m_ovf = 1'b0;
    logic        m_udf = 1'b0;

    io_input_fifo #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .DIn     (DIn),
        .full    (full),
        .empty   (empty),
        .count   (count)
`ifdef IO_INPUT_FIFO_ERRFLAG_EN
        ,
        .ovf     (ovf),
        .udf     (udf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] exp_din;
        exp_din = (q.size() > 0) ? q[0] : 32'h0;
        check({tag, ".count"}, 32'(count), 32'(q.size()));
        check({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
        check({tag, ".full"},  32'(full),  32'(q.size() == DEPTH));
        check({tag, ".DIn"},   DIn,        exp_din);
`ifdef IO_INPUT_FIFO_ERRFLAG_EN
        check({tag, ".ovf"},   32'(ovf),   32'(m_ovf));
        check({tag, ".udf"},   32'(udf),   32'(m_udf));
`endif
    endtask

    // One clock: drive, model the edge from the pre-edge contents, then check
    task automatic step(input logic w, input logic [31:0] d, input logic r, input string tag);
        bit rd_ok, wr_ok;
        wr_en = w; wr_data = d; rd_en = r;
        @(posedge clk);
        rd_ok = r && (q.size() > 0);
        wr_ok = w && ((q.size() < DEPTH) || rd_ok);
        if (w && !wr_ok)              m_ovf = 1'b1;
        if (r && q.size() == 0 && !w) m_udf = 1'b1;
        if (rd_ok) void'(q.pop_front());
        if (wr_ok) q.push_back(d);
        #1;
        wr_en = 1'b0; rd_en = 1'b0;
        check_all(tag);
    endtask

    task automatic do_reset(input logic w, input logic r);
        reset = 1'b1; wr_en = w; wr_data = 32'h5555_AAAA; rd_en = r;
        @(posedge clk);
        q.delete(); m_ovf = 1'b0; m_udf = 1'b0;
        #1;
        reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        check_all("reset");
    endtask

    initial begin
        // Reset state
        do_reset(1'b0, 1'b0);

        // Three writes then three reads
        step(1, 32'h11, 0, "w11");
        step(1, 32'h22, 0, "w22");
        step(1, 32'h33, 0, "w33");
        check("three.DIn", DIn, 32'h11);
        check("three.count", 32'(count), 32'd3);
        step(0, 0, 1, "r1");
        check("r1.DIn", DIn, 32'h22);
        step(0, 0, 1, "r2");
        check("r2.DIn", DIn, 32'h33);
        step(0, 0, 1, "r3");
        check("r3.DIn", DIn, 32'h0);

        // Overfill: word 9 dropped, then read 1..8
        do_reset(1'b0, 1'b0);
        for (int i = 1; i <= 9; i++) step(1, 32'(i), 0, "fill");
        check("ovfill.full", 32'(full), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            check("drain.head", DIn, 32'(i));
            step(0, 0, 1, "drain");
        end
        check("drain.empty", 32'(empty), 32'd1);

        // Underflow attempt on an empty FIFO
        step(0, 0, 1, "udf");

        // Read and write together while full
        do_reset(1'b0, 1'b0);
        for (int i = 1; i <= 8; i++) step(1, 32'(i), 0, "fill2");
        step(1, 32'hDEAD_BEEF, 1, "fullrw");
        check("fullrw.DIn", DIn, 32'd2);
        for (int i = 2; i <= 8; i++) step(0, 0, 1, "drain2");
        check("last.DIn", DIn, 32'hDEAD_BEEF);
        step(0, 0, 1, "drain2");

        // Read and write together while empty
        do_reset(1'b0, 1'b0);
        step(1, 32'hCAFE_0001, 1, "emptyrw");
        check("emptyrw.DIn", DIn, 32'hCAFE_0001);

        // Mid-stream reset with a write pending
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1, 32'h100 + 32'(i), 0, "fill5");
        do_reset(1'b1, 1'b1);
        check("rst.DIn", DIn, 32'h0);

        // Randomized stream with gaps, long enough to wrap pointers many times
        for (int i = 0; i < 300; i++) begin
            logic w, r;
            w = ($urandom_range(0, 99) < 60);
            r = ($urandom_range(0, 99) < ((i % 80) < 40 ? 30 : 70));
            step(w, $urandom, r, "rand");
        end
        while (q.size() > 0) step(0, 0, 1, "flush");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
